// File: rtl/regfile_pkg.sv
// Shared defaults, arbitration mode codes and a decode helper for the register-file write path.
// Pure definitions: no latency and no flow control of its own.
package regfile_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_CH_DEF   = 2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int COLL_W = 8;

    function automatic logic [NUM_REGS_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] a);
        logic [NUM_REGS_DEF-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Address to one-hot wordline decoder with enable; all zeros when disabled.
// Purely combinational; no backpressure.
module reg_onehot_dec #(
    parameter int ADDR_W = 4
) (
    input  logic                 en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [2**ADDR_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arb.sv
// Registered multi-channel register-file write front-end with same-address combining.
// One buffer per channel, one commit per cycle (wordline two edges after accept); a full channel stalls until granted.
module regfile_write_arb
    import regfile_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int ZERO_REG_EN = 1,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_valid,
    output logic [NUM_CH-1:0]        wr_ready,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic [NUM_REGS-1:0]      wordline,
    output logic [DATA_W-1:0]        wdata,
    output logic                     commit,
    output logic [NUM_REGS-1:0]      pending,
    output logic [COLL_W-1:0]        coll_cnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] buf_v_q, buf_v_d;
    logic [ADDR_W-1:0] buf_addr_q [NUM_CH];
    logic [ADDR_W-1:0] buf_addr_d [NUM_CH];
    logic [DATA_W-1:0] buf_data_q [NUM_CH];
    logic [DATA_W-1:0] buf_data_d [NUM_CH];

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REGS-1:0] wordline_q, wordline_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                commit_q, commit_d;
    logic [COLL_W-1:0]   coll_q, coll_d;

    logic              any_grant;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  rr_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NUM_CH-1:0] grant, retire, accept;
    logic [2:0]        n_extra;
    logic [COLL_W:0]   coll_sum;
    logic              wl_en;

    // Later iterations override earlier ones, so the loop order sets the priority.
    always_comb begin
        any_grant = |buf_v_q;
        win_idx   = '0;
        rr_idx    = '0;
        if (ARB_MODE == ARB_RR) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                rr_idx = PTR_W'((int'(ptr_q) + k) % NUM_CH);
                if (buf_v_q[rr_idx]) begin
                    win_idx = rr_idx;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (buf_v_q[i]) begin
                    win_idx = PTR_W'(i);
                end
            end
        end
    end

    assign win_addr = buf_addr_q[win_idx];
    assign win_data = buf_data_q[win_idx];

    // Every valid buffer aimed at the winner's register retires with it; only W's data lands.
    always_comb begin
        grant   = '0;
        retire  = '0;
        n_extra = '0;
        if (any_grant) begin
            grant[win_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (any_grant && buf_v_q[i] && (buf_addr_q[i] == win_addr)) begin
                retire[i] = 1'b1;
                if (!grant[i]) begin
                    n_extra = n_extra + 3'd1;
                end
            end
        end
    end

    assign wr_ready = {NUM_CH{~rst}} & (~buf_v_q | grant);
    assign accept   = wr_valid & wr_ready;

    always_comb begin
        buf_v_d    = buf_v_q & ~retire;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                buf_v_d[i]    = 1'b1;
                buf_addr_d[i] = wr_addr[i*ADDR_W +: ADDR_W];
                buf_data_d[i] = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE == ARB_RR) && any_grant) begin
            ptr_d = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    assign coll_sum = {1'b0, coll_q} + {{(COLL_W-2){1'b0}}, n_extra};
    assign coll_d   = coll_sum[COLL_W] ? {COLL_W{1'b1}} : coll_sum[COLL_W-1:0];

    assign wl_en    = any_grant && !((ZERO_REG_EN != 0) && (win_addr == '0));
    assign commit_d = any_grant;
    assign wdata_d  = any_grant ? win_data : wdata_q;

    reg_onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en_i     (wl_en),
        .addr_i   (win_addr),
        .onehot_o (wordline_d)
    );

    always_comb begin
        pending = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (buf_v_q[i]) begin
                    pending[buf_addr_q[i]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q    <= '0;
            ptr_q      <= '0;
            wordline_q <= '0;
            wdata_q    <= '0;
            commit_q   <= 1'b0;
            coll_q     <= '0;
        end else begin
            buf_v_q    <= buf_v_d;
            ptr_q      <= ptr_d;
            wordline_q <= wordline_d;
            wdata_q    <= wdata_d;
            commit_q   <= commit_d;
            coll_q     <= coll_d;
        end
    end

    // Payload is qualified by buf_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
    end

    assign wordline = wordline_q;
    assign wdata    = wdata_q;
    assign commit   = commit_q;
    assign coll_cnt = coll_q;

endmodule

// File: tb/tb_regfile_write_arb.sv
// Directed bench: a fixed-priority 2-channel instance driven from a vector table,
// and a 3-channel round-robin instance for streaming fairness and counter saturation.
module tb_regfile_write_arb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        fx_rst = 1'b1;
    logic [1:0]  fx_valid = '0;
    logic [7:0]  fx_addr = '0;
    logic [31:0] fx_data = '0;
    logic [1:0]  fx_ready;
    logic [15:0] fx_wl, fx_wdata, fx_pending;
    logic        fx_commit;
    logic [7:0]  fx_coll;

    logic        rr_rst = 1'b1;
    logic [2:0]  rr_valid = '0;
    logic [11:0] rr_addr = '0;
    logic [47:0] rr_data = '0;
    logic [2:0]  rr_ready;
    logic [15:0] rr_wl, rr_wdata, rr_pending;
    logic        rr_commit;
    logic [7:0]  rr_coll;

    regfile_write_arb #(
        .NUM_REGS(16), .DATA_W(16), .NUM_CH(2), .ARB_MODE(ARB_FIXED), .ZERO_REG_EN(1)
    ) dut_fx (
        .clk(clk), .rst(fx_rst), .wr_valid(fx_valid), .wr_ready(fx_ready),
        .wr_addr(fx_addr), .wr_data(fx_data), .wordline(fx_wl), .wdata(fx_wdata),
        .commit(fx_commit), .pending(fx_pending), .coll_cnt(fx_coll)
    );

    regfile_write_arb #(
        .NUM_REGS(16), .DATA_W(16), .NUM_CH(3), .ARB_MODE(ARB_RR), .ZERO_REG_EN(1)
    ) dut_rr (
        .clk(clk), .rst(rr_rst), .wr_valid(rr_valid), .wr_ready(rr_ready),
        .wr_addr(rr_addr), .wr_data(rr_data), .wordline(rr_wl), .wdata(rr_wdata),
        .commit(rr_commit), .pending(rr_pending), .coll_cnt(rr_coll)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [3:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [1:0]  rdy;
        logic [15:0] pend;
        logic [15:0] wl, wd;
        logic        cm;
        logic [7:0]  cc;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    int n_applied = 0;
    int n_miss    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int wins [3];
        int mono_bad, wl_bad;
        logic [7:0] prev_coll;

        //          rst vld   a0    a1    d0        d1        rdy   pend      wl        wd        cm    cc
        tbl[0]  = '{1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 2'b01, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0020, 16'h0020, 16'hBEEF, 1'b1, 8'd0};
        tbl[3]  = '{1'b0, 2'b11, 4'd3, 4'd7, 16'h1111, 16'h7777, 2'b11, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b10, 16'h0088, 16'h0080, 16'h7777, 1'b1, 8'd0};
        tbl[5]  = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0008, 16'h0008, 16'h1111, 1'b1, 8'd0};
        tbl[6]  = '{1'b0, 2'b11, 4'd4, 4'd4, 16'hAAAA, 16'hBBBB, 2'b11, 16'h0000, 16'h0000, 16'h1111, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b10, 16'h0010, 16'h0010, 16'hBBBB, 1'b1, 8'd1};
        tbl[8]  = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'hBBBB, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 2'b10, 4'd0, 4'd0, 16'h0000, 16'hCCCC, 2'b11, 16'h0000, 16'h0000, 16'hBBBB, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0001, 16'h0000, 16'hCCCC, 1'b1, 8'd1};
        tbl[11] = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'hCCCC, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 2'b11, 4'd2, 4'd6, 16'h1212, 16'h6666, 2'b11, 16'h0000, 16'h0000, 16'hCCCC, 1'b0, 8'd1};
        tbl[13] = '{1'b1, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[15] = '{1'b0, 2'b01, 4'd9, 4'd0, 16'h0909, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[16] = '{1'b0, 2'b01, 4'hA, 4'd0, 16'h0A0A, 16'h0000, 2'b11, 16'h0200, 16'h0200, 16'h0909, 1'b1, 8'd0};
        tbl[17] = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0400, 16'h0400, 16'h0A0A, 1'b1, 8'd0};
        tbl[18] = '{1'b0, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0A0A, 1'b0, 8'd0};

        @(posedge clk);
        #1;

        // Inputs for row i go in just after an edge; ready/pending are checked before the
        // next edge, registered outputs just after it.
        for (int i = 0; i < NV; i++) begin
            fx_rst   = tbl[i].rst;
            fx_valid = tbl[i].vld;
            fx_addr  = {tbl[i].a1, tbl[i].a0};
            fx_data  = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i),   32'(fx_ready),   32'(tbl[i].rdy));
            chk($sformatf("v%0d_pending", i), 32'(fx_pending), 32'(tbl[i].pend));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wordline", i), 32'(fx_wl),     32'(tbl[i].wl));
            chk($sformatf("v%0d_wdata", i),    32'(fx_wdata),  32'(tbl[i].wd));
            chk($sformatf("v%0d_commit", i),   32'(fx_commit), 32'(tbl[i].cm));
            chk($sformatf("v%0d_coll", i),     32'(fx_coll),   32'(tbl[i].cc));
        end

        // Round-robin streaming: distinct targets R1/R2/R3, data = channel + 1.
        rr_rst   = 1'b0;
        rr_valid = 3'b111;
        rr_addr  = {4'd3, 4'd2, 4'd1};
        rr_data  = {16'd3, 16'd2, 16'd1};
        wins     = '{0, 0, 0};
        @(posedge clk);
        #1;
        chk("rr_ready_first", 32'(rr_ready), 32'h1);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rr_c%0d_commit", c), 32'(rr_commit), 32'h1);
            chk($sformatf("rr_c%0d_wordline", c), 32'(rr_wl), 32'(onehot(4'((c % 3) + 1))));
            chk($sformatf("rr_c%0d_wdata", c), 32'(rr_wdata), 32'((c % 3) + 1));
            chk($sformatf("rr_c%0d_ready", c), 32'(rr_ready), 32'(3'b001 << ((c + 1) % 3)));
            for (int k = 0; k < 3; k++) begin
                if (rr_wl == onehot(4'(k + 1))) wins[k]++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rr_share_ch%0d", k), 32'(wins[k]), 32'd3);
        end
        chk("rr_coll_distinct", 32'(rr_coll), 32'd0);

        // Same target on all channels: every cycle with a combine bumps the counter.
        rr_rst   = 1'b1;
        rr_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("rr_rst_coll", 32'(rr_coll), 32'd0);
        rr_rst    = 1'b0;
        rr_valid  = 3'b111;
        rr_addr   = {4'd9, 4'd9, 4'd9};
        mono_bad  = 0;
        wl_bad    = 0;
        prev_coll = 8'd0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk);
            #1;
            if (rr_coll < prev_coll) mono_bad++;
            if (!$onehot0(rr_wl)) wl_bad++;
            prev_coll = rr_coll;
        end
        chk("rr_coll_saturated", 32'(rr_coll), 32'd255);
        chk("rr_coll_monotonic", 32'(mono_bad), 32'd0);
        chk("rr_wordline_onehot", 32'(wl_bad), 32'd0);
        chk("rr_pending_r9", 32'(rr_pending), 32'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
